// File: rtl/alarm_pkg.sv
// Shared definitions for the anti-theft alarm controller: state codes, interval
// select codes and timer width.
package alarm_pkg;

    localparam int TIMER_W = 5;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGER    = 3'd1,
        ST_ALARM_ON   = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_ARMING     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        INT_ARM    = 2'b00,
        INT_DRIVER = 2'b01,
        INT_PASS   = 2'b10,
        INT_ALARM  = 2'b11
    } interval_t;

endpackage

// File: rtl/interval_timer.sv
// Seconds down-counter with a one-cycle deferred load, so the parameter block has
// a cycle to present the duration selected by the new interval.
module interval_timer
    import alarm_pkg::*;
#(
    parameter bit TICK_IGNORE_ON_LOAD = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    input  logic               clear,
    output logic               expired
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;

    // A held load request keeps re-arming the pending flag, so the count stays
    // pinned to the parameter value until the request drops.
    always_comb begin
        count_d   = count_q;
        pending_d = load;
        if (clear) begin
            count_d   = '0;
            pending_d = 1'b0;
        end else if (pending_q) begin
            if (tick && !TICK_IGNORE_ON_LOAD && (load_value != '0)) begin
                count_d = load_value - ONE;
            end else begin
                count_d = load_value;
            end
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign expired = (count_q == '0) && !pending_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencing FSM: tracks doors and ignition, selects the timing parameter
// through interval, and drives siren and status LED.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter bit TICK_IGNORE_ON_LOAD = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               ignition,
    input  logic               door_driver,
    input  logic               door_pass,
    input  logic               reprogram,
    input  logic [TIMER_W-1:0] value,
    output logic [1:0]         interval,
    output logic               siren,
    output logic               status,
    output logic [2:0]         state
);

    state_t    state_q, state_d;
    interval_t interval_q, interval_d;
    logic      blink_q, blink_d;
    logic      load;
    logic      clear;
    logic      expired;
    logic      door_open;

    interval_timer #(
        .TICK_IGNORE_ON_LOAD(TICK_IGNORE_ON_LOAD)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (value),
        .tick       (tick),
        .clear      (clear),
        .expired    (expired)
    );

    assign door_open = door_driver | door_pass;

    // reprogram outranks ignition, which outranks every ordinary transition.
    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        load       = 1'b0;
        clear      = 1'b0;
        if (reprogram) begin
            state_d = ST_ARMED;
            clear   = 1'b1;
        end else if (ignition) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (door_driver) begin
                        state_d    = ST_TRIGGER;
                        interval_d = INT_DRIVER;
                        load       = 1'b1;
                    end else if (door_pass) begin
                        state_d    = ST_TRIGGER;
                        interval_d = INT_PASS;
                        load       = 1'b1;
                    end
                end
                ST_TRIGGER: begin
                    if (expired) begin
                        state_d    = ST_ALARM_ON;
                        interval_d = INT_ALARM;
                        load       = 1'b1;
                    end
                end
                ST_ALARM_ON: begin
                    if (door_open) begin
                        load = 1'b1;
                    end else if (expired) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DISARMED:   state_d = ST_WAIT_OPEN;
                ST_WAIT_OPEN: begin
                    if (door_driver) begin
                        state_d = ST_WAIT_CLOSE;
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (!door_driver) begin
                        state_d    = ST_ARMING;
                        interval_d = INT_ARM;
                        load       = 1'b1;
                    end
                end
                ST_ARMING: begin
                    if (door_open) begin
                        load = 1'b1;
                    end else if (expired) begin
                        state_d = ST_ARMED;
                    end
                end
                default:       state_d = ST_ARMED;
            endcase
        end
    end

    // The blink phase restarts from 0 every time ARMED is entered.
    always_comb begin
        blink_d = 1'b0;
        if (state_q == ST_ARMED) begin
            blink_d = blink_q ^ tick;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ARMED;
            interval_q <= INT_ARM;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            blink_q    <= blink_d;
        end
    end

    always_comb begin
        status = 1'b0;
        case (state_q)
            ST_ARMED:                status = blink_q;
            ST_TRIGGER, ST_ALARM_ON: status = 1'b1;
            default:                 status = 1'b0;
        endcase
    end

    assign siren    = (state_q == ST_ALARM_ON);
    assign interval = interval_q;
    assign state    = state_q;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing FSM for the anti-theft alarm: watches ignition and door sensors, selects which time parameter the `Parametros_Tempo` block presents on `value` through `interval`, and counts that duration in seconds using a 1 Hz enable. It sits between the parameter block and the siren/status outputs, and is the only driver of `interval`.

## Interface
- `TICK_IGNORE_ON_LOAD`, 1: when 1, a `tick` that coincides with the counter-load cycle is discarded.
- `clock  in  1`: system clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `tick  in  1`: one-cycle 1 Hz enable pulse.
- `ignition  in  1`: 1 = ignition on.
- `door_driver  in  1`: 1 = driver door open.
- `door_pass  in  1`: 1 = passenger door open.
- `reprogram  in  1`: the same strobe that is sent to the parameter block. Forces the controller to ARMED.
- `value  in  5`: selected duration in seconds, from the parameter block.
- `interval  out  2`: parameter select. 00 = T_ARM_DELAY, 01 = T_DRIVER_DELAY, 10 = T_PASSENGER_DELAY, 11 = T_ALARM_ON.
- `siren  out  1`: 1 while the alarm sounds.
- `status  out  1`: status LED.
- `state  out  3`: current state code, for debug.

## Operation
States and codes: ARMED 0, TRIGGER 1, ALARM_ON 2, DISARMED 3, WAIT_OPEN 4, WAIT_CLOSE 5, ARMING 6.

`ignition`=1 moves every state to DISARMED. This has priority over all transitions except reset and `reprogram`.

- **ARMED**
  - `door_driver` → TRIGGER with `interval`=01.
  - Otherwise `door_pass` → TRIGGER with `interval`=10.
  - If both doors open in the same cycle, the driver door wins.
- **TRIGGER**: timer expired → ALARM_ON with `interval`=11.
- **ALARM_ON**
  - `siren`=1.
  - While either door is open, the timer is held reloaded.
  - With both doors closed, the countdown runs; on expiry → ARMED.
- **DISARMED**: `ignition`=0 → WAIT_OPEN.
- **WAIT_OPEN**: `door_driver`=1 → WAIT_CLOSE.
- **WAIT_CLOSE**: `door_driver`=0 → ARMING with `interval`=00.
- **ARMING**
  - Any door open → timer reloaded; stay in ARMING.
  - On expiry → ARMED.

`status` per state:
- ARMED: toggles on every `tick`.
- TRIGGER and ALARM_ON: 1.
- All other states: 0.

`reprogram`=1 (synchronous, below reset in priority):
- Next state is ARMED.
- Timer cleared to 0.
- `interval` keeps its current value.

Timer (5-bit down-counter):
- Loaded from `value`.
- Decrements on `tick` while nonzero.
- Expired = count==0 and no load pending.
- `value`=0 expires on the cycle after the load.
- No wrap: the counter never decrements below 0.

## Timing
Reset values:
- State ARMED.
- `interval`=00, `siren`=0, `status`=0, `state`=0.
- Counter 0; load-pending 0.

`interval` is registered and updates on the same edge as the state transition.

Counter load sequence:
- `value` is valid one cycle after `interval` changes.
- Entering a timed state sets load-pending.
- The counter loads `value` on the next edge, which clears load-pending.
- A reload request (door open in ARMING or ALARM_ON) uses the same one-cycle load; `interval` is unchanged.

Expiry latency: the transition occurs on the first edge where the count is 0, i.e. one clock after the tick that took the count 1→0.

Simultaneous events:
- `ignition` together with expiry → DISARMED.
- `reprogram` together with `ignition` → ARMED, then DISARMED next cycle if `ignition` is still 1.

Reset asserted mid-countdown: immediate return to reset values; no siren glitch.

## Structure
Shared package `alarm_pkg`:
- State codes.
- Interval codes (`INT_ARM`, `INT_DRIVER`, `INT_PASS`, `INT_ALARM`).
- Timer width 5.

Sub-module `interval_timer`:
- Ports: `clock`, `reset`, `load`, `load_value[4:0]`, `tick`, `clear`, `expired`.
- Owns the down-counter and load-pending logic.

FSM and output logic stay in `alarm_controller`.

## Test plan
Bench setup: parameter defaults 6/8/15/10, `tick` every 4 clocks.

1. Reset, then open the driver door.
   - `interval`=01 and `state`=1.
   - After 8 ticks: `siren`=1, `interval`=11.
   - Close the door; after 10 ticks: `state`=0, `siren`=0.
2. Open the passenger door only.
   - `interval`=10.
   - `siren` rises after 15 ticks.
3. Open both doors in the same cycle → `interval`=01.
   - Assert `ignition` at tick 3 → `state`=3, `siren` never 1.
4. Disarm sequence: ignition off → open driver door → close driver door.
   - `interval`=00.
   - Reopen the passenger door at tick 4, then close it; ARMED is reached 6 ticks after the close.
5. In ALARM_ON, pulse `reprogram` with `time_value`=5 on `interval` 01.
   - Next cycle: `state`=0, counter 0.
   - Open the driver door: expiry after 5 ticks.
6. Drop `reset` mid-TRIGGER at count 3 → all outputs at reset values immediately, with no clock edge required.
   - Release `reset`: ARMED; `status` toggles on the next tick.
